// File: rtl/instr_encoder_if.sv
// Request and IMEM-write bundle for instr_encoder: slave is the encoder,
// master is the requester that also plays the IMEM write port.
interface instr_encoder_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_class;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [11:0]       req_imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_class, req_rd, req_rs1, req_rs2,
           req_funct3, req_funct7, req_imm, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_class, req_rd, req_rs1, req_rs2,
           req_funct3, req_funct7, req_imm, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I/F instruction assembler feeding IMEM writes through a word FIFO.
// Latency 1 from accept to imem_we; req_ready drops when the FIFO is full, an IMEM stall holds the head.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_encoder_if.slave    bus,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              err_illegal,
  output logic [15:0]       word_count
);
  typedef enum logic [3:0] {
    CL_LW, CL_SW, CL_R, CL_I, CL_BEQ, CL_FLW, CL_FSW, CL_FP,
    CL_FCVT_S_W, CL_FCVT_W_S, CL_FMV_W_X, CL_FMV_X_W
  } cls_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  cls_t              req_cls;
  rtype_t            enc;
  logic              illegal;
  logic              accept;
  logic              push_vld;
  logic              pop_vld;
  logic              empty;
  logic              full;
  logic [31:0]       head_dat;
  logic [ADDR_W-1:0] wr_addr;

  assign req_cls = cls_t'(bus.req_class);

  // Immediate layouts reuse the R-type slots: I puts imm in funct7:rs2,
  // S/B split theirs across funct7 and rd.
  always_comb begin
    enc         = '0;
    illegal     = 1'b0;
    enc.rd      = bus.req_rd;
    enc.rs1     = bus.req_rs1;
    enc.rs2     = bus.req_rs2;
    enc.funct3  = bus.req_funct3;
    enc.funct7  = bus.req_funct7;
    case (req_cls)
      CL_LW, CL_FLW: begin
        enc.opcode             = (req_cls == CL_LW) ? 7'b0000011 : 7'b0000111;
        enc.funct3             = 3'b010;
        {enc.funct7, enc.rs2}  = bus.req_imm;
      end
      CL_SW, CL_FSW: begin
        enc.opcode = (req_cls == CL_SW) ? 7'b0100011 : 7'b0100111;
        enc.funct3 = 3'b010;
        enc.funct7 = bus.req_imm[11:5];
        enc.rd     = bus.req_imm[4:0];
      end
      CL_R: enc.opcode = 7'b0110011;
      CL_I: begin
        enc.opcode             = 7'b0010011;
        {enc.funct7, enc.rs2}  = bus.req_imm;
      end
      CL_BEQ: begin
        // req_imm holds offset[12:1], so offset[n] sits at req_imm[n-1].
        enc.opcode = 7'b1100011;
        enc.funct3 = 3'b000;
        enc.funct7 = {bus.req_imm[11], bus.req_imm[9:4]};
        enc.rd     = {bus.req_imm[3:0], bus.req_imm[10]};
      end
      CL_FP: enc.opcode = 7'b1010011;
      CL_FCVT_S_W, CL_FCVT_W_S: begin
        enc.opcode = 7'b1010011;
        enc.funct7 = (req_cls == CL_FCVT_S_W) ? 7'b1101000 : 7'b1100000;
        enc.rs2    = 5'd0;
      end
      CL_FMV_W_X, CL_FMV_X_W: begin
        enc.opcode = 7'b1010011;
        enc.funct7 = (req_cls == CL_FMV_W_X) ? 7'b1111000 : 7'b1110000;
        enc.rs2    = 5'd0;
        enc.funct3 = 3'b000;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign bus.req_ready  = !full;
  assign accept         = bus.req_valid && bus.req_ready;
  assign push_vld       = accept && !illegal;
  assign pop_vld        = bus.imem_we && bus.imem_ready;
  assign busy           = !empty;
  assign bus.imem_we    = busy;
  assign bus.imem_wdata = head_dat;
  assign bus.imem_addr  = wr_addr;

  fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_vld),
    .push_dat (enc),
    .pop      (pop_vld),
    .pop_dat  (head_dat),
    .empty    (empty),
    .full     (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr     <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else begin
      // A load coinciding with a pop wins: that write already used the old address.
      if (addr_load)    wr_addr <= base_addr;
      else if (pop_vld) wr_addr <= wr_addr + ADDR_W'(4);
      if (pop_vld)      word_count <= word_count + 16'd1;
      if (accept && illegal) err_illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus backpressure, illegal,
// reset and address-wrap sequences, all expectations hand-computed.
module tb_instr_encoder;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              addr_load;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              err_illegal;
  logic [15:0]       word_count;
  int                n_cmp = 0;
  int                n_err = 0;
  int                exp_wc;
  vec_t              tbl [16];

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .addr_load   (addr_load),
    .base_addr   (base_addr),
    .busy        (busy),
    .err_illegal (err_illegal),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_class  = v.cls;
    bus.req_rd     = v.rd;
    bus.req_rs1    = v.rs1;
    bus.req_rs2    = v.rs2;
    bus.req_funct3 = v.f3;
    bus.req_funct7 = v.f7;
    bus.req_imm    = v.imm;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(bus.imem_we), 32'd0);
    check({tag, "_addr"},  bus.imem_addr, 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_err"},   32'(err_illegal), 32'd0);
    check({tag, "_wc"},    32'(word_count), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    //             cls    rd     rs1    rs2    f3    f7       imm       expected word
    tbl[0]  = '{4'd0,  5'd5,  5'd2,  5'd9,  3'd7, 7'h00, 12'h008, 32'h00812283}; // lw
    tbl[1]  = '{4'd1,  5'd31, 5'd2,  5'd5,  3'd0, 7'h7F, 12'h00C, 32'h00512623}; // sw
    tbl[2]  = '{4'd4,  5'd31, 5'd1,  5'd2,  3'd5, 7'h00, 12'h008, 32'h00208863}; // beq +16
    tbl[3]  = '{4'd8,  5'd1,  5'd10, 5'd7,  3'd0, 7'h55, 12'h000, 32'hD00500D3}; // fcvt.s.w
    tbl[4]  = '{4'd7,  5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 12'h000, 32'h002081D3}; // fadd.s
    tbl[5]  = '{4'd2,  5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 12'h000, 32'h402081B3}; // sub
    tbl[6]  = '{4'd3,  5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 12'hFFF, 32'hFFF00093}; // addi -1
    tbl[7]  = '{4'd5,  5'd1,  5'd2,  5'd0,  3'd0, 7'h00, 12'h004, 32'h00412087}; // flw
    tbl[8]  = '{4'd6,  5'd0,  5'd2,  5'd3,  3'd0, 7'h00, 12'h008, 32'h00312427}; // fsw
    tbl[9]  = '{4'd9,  5'd5,  5'd1,  5'd3,  3'd1, 7'h00, 12'h000, 32'hC00092D3}; // fcvt.w.s rtz
    tbl[10] = '{4'd10, 5'd2,  5'd10, 5'd9,  3'd7, 7'h00, 12'h000, 32'hF0050153}; // fmv.w.x
    tbl[11] = '{4'd11, 5'd10, 5'd2,  5'd0,  3'd3, 7'h00, 12'h000, 32'hE0010553}; // fmv.x.w
    tbl[12] = '{4'd4,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 12'hFFE, 32'hFE000EE3}; // beq -4
    tbl[13] = '{4'd1,  5'd0,  5'd2,  5'd5,  3'd0, 7'h00, 12'hFFC, 32'hFE512E23}; // sw -4
    tbl[14] = '{4'd2,  5'd7,  5'd5,  5'd6,  3'd7, 7'h00, 12'h000, 32'h0062F3B3}; // and
    tbl[15] = '{4'd3,  5'd6,  5'd5,  5'd0,  3'd7, 7'h00, 12'h07F, 32'h07F2F313}; // andi

    rst_n = 1'b0; addr_load = 1'b0; base_addr = '0;
    bus.req_valid = 1'b0; bus.req_class = '0; bus.req_rd = '0; bus.req_rs1 = '0;
    bus.req_rs2 = '0; bus.req_funct3 = '0; bus.req_funct7 = '0; bus.req_imm = '0;
    bus.imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1; addr_load = 1'b1; base_addr = 32'h100; bus.imem_ready = 1'b1;
    @(negedge clk);
    addr_load = 1'b0;
    #1 check("addr_load", bus.imem_addr, 32'h100);

    exp_wc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 if (i == 0) check("no_bypass_we", 32'(bus.imem_we), 32'd0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_we", i), 32'(bus.imem_we), 32'd1);
      check($sformatf("vec%0d_wdata", i), bus.imem_wdata, tbl[i].exp);
      check($sformatf("vec%0d_addr", i), bus.imem_addr, 32'h100 + 32'(4 * i));
      @(negedge clk);
      exp_wc++;
      #1;
      check($sformatf("vec%0d_wc", i), 32'(word_count), 32'(exp_wc));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
    end

    // Backpressure: five back-to-back requests into a stalled IMEM port.
    @(negedge clk);
    bus.imem_ready = 1'b0; addr_load = 1'b1; base_addr = 32'h300;
    @(negedge clk);
    addr_load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      drive(tbl[k]);
      #1;
      check($sformatf("bp_ready%0d", k), 32'(bus.req_ready), (k < 4) ? 32'd1 : 32'd0);
      if (k > 0) begin
        check($sformatf("bp_hold_wdata%0d", k), bus.imem_wdata, tbl[0].exp);
        check($sformatf("bp_hold_addr%0d", k), bus.imem_addr, 32'h300);
      end
    end
    @(negedge clk);
    #1;
    check("bp_full_ready", 32'(bus.req_ready), 32'd0);
    check("bp_stall_wdata", bus.imem_wdata, tbl[0].exp);
    check("bp_stall_addr", bus.imem_addr, 32'h300);
    check("bp_stall_wc", 32'(word_count), 32'(exp_wc));
    bus.imem_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("bp_drain_wdata%0d", j), bus.imem_wdata, tbl[j].exp);
      check($sformatf("bp_drain_addr%0d", j), bus.imem_addr, 32'h300 + 32'(4 * j));
      if (j == 1) check("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
      if (j == 2) bus.req_valid = 1'b0;
    end
    @(negedge clk);
    exp_wc += 5;
    #1;
    check("bp_empty", 32'(busy), 32'd0);
    check("bp_wc", 32'(word_count), 32'(exp_wc));

    // Illegal class: accepted, nothing written, sticky error.
    @(negedge clk);
    drive('{4'd13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 12'h000, 32'h0});
    #1 check("ill_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("ill_no_we", 32'(bus.imem_we), 32'd0);
    check("ill_err", 32'(err_illegal), 32'd1);
    @(negedge clk);
    drive(tbl[0]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("ill_then_legal_wdata", bus.imem_wdata, tbl[0].exp);
    check("ill_then_legal_addr", bus.imem_addr, 32'h314);
    @(negedge clk);
    exp_wc++;
    #1;
    check("ill_err_sticky", 32'(err_illegal), 32'd1);
    check("ill_wc", 32'(word_count), 32'(exp_wc));

    // Reset while words are still queued.
    bus.imem_ready = 1'b0;
    @(negedge clk);
    drive(tbl[1]);
    @(negedge clk);
    drive(tbl[2]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Address wrap, then addr_load coinciding with a pop.
    bus.imem_ready = 1'b1; addr_load = 1'b1; base_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    addr_load = 1'b0;
    drive(tbl[3]);
    @(negedge clk);
    drive(tbl[4]);
    #1;
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    check("wrap_wdata0", bus.imem_wdata, tbl[3].exp);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("wrap_addr1", bus.imem_addr, 32'h0);
    check("wrap_wdata1", bus.imem_wdata, tbl[4].exp);
    @(negedge clk);
    drive(tbl[5]);
    @(negedge clk);
    drive(tbl[6]);
    addr_load = 1'b1; base_addr = 32'h200;
    #1;
    check("ld_pop_old_addr", bus.imem_addr, 32'h4);
    check("ld_pop_wdata", bus.imem_wdata, tbl[5].exp);
    @(negedge clk);
    addr_load = 1'b0; bus.req_valid = 1'b0;
    #1;
    check("ld_pop_new_addr", bus.imem_addr, 32'h200);
    check("ld_pop_next_wdata", bus.imem_wdata, tbl[6].exp);
    @(negedge clk);
    #1;
    check("final_busy", 32'(busy), 32'd0);
    check("final_wc", 32'(word_count), 32'd4);
    check("final_addr", bus.imem_addr, 32'h204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
